cordic_host_if: RTL and testbench
=================================

Name: cordic_host_if

Overview:
- Host-side counterpart of the CORDIC core's packed valid/data interface.
- Takes CORDIC operations from a valid/ready requester, packs them into the core's TOTAL_WIDTH input word, and unpacks results returned on the core's output.
- Returns results through a small result FIFO with valid/ready handshaking.
- The core has no backpressure, so the block issues requests against credits: a request is issued only when a FIFO slot is guaranteed for its result.

Parameters:
- TOTAL_WIDTH, 49, packed core word width; must equal 3*DATA_WIDTH+1.
- DATA_WIDTH, 16, width of each of the x, y and z fields.
- FIFO_DEPTH, 8, result FIFO entries and total credits; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of the credit and occupancy counters.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_vld  input  1  request valid.
- o_req_rdy  output  1  request ready; a request is accepted when i_req_vld and o_req_rdy are both high.
- i_req_mode  input  1  0 = rotation, 1 = vectoring.
- i_req_x  input  DATA_WIDTH  x operand.
- i_req_y  input  DATA_WIDTH  y operand.
- i_req_z  input  DATA_WIDTH  z operand (angle).
- o_cdc_vld  output  1  issue strobe to the core's i_vld.
- o_cdc_data  output  TOTAL_WIDTH  packed word to the core's i_data.
- i_cdc_vld  input  1  result strobe from the core's o_vld.
- i_cdc_data  input  TOTAL_WIDTH  packed word from the core's o_data.
- o_rsp_vld  output  1  result valid (FIFO not empty).
- i_rsp_rdy  input  1  result ready; the FIFO pops when o_rsp_vld and i_rsp_rdy are both high.
- o_rsp_mode  output  1  unpacked mode field of the head entry.
- o_rsp_x  output  DATA_WIDTH  unpacked x field of the head entry.
- o_rsp_y  output  DATA_WIDTH  unpacked y field of the head entry.
- o_rsp_z  output  DATA_WIDTH  unpacked z field of the head entry.
- o_inflight  output  CNT_W  number of requests issued to the core whose results have not yet returned.
- o_busy  output  1  high when inflight is non-zero or the FIFO is non-empty.
- o_err  output  1  sticky error flag: spurious result or FIFO overflow.

Behaviour:
- Word packing, the same format in both directions:
  - bit [3*DATA_WIDTH] = mode.
  - [3*DATA_WIDTH-1:2*DATA_WIDTH] = x.
  - [2*DATA_WIDTH-1:DATA_WIDTH] = y.
  - [DATA_WIDTH-1:0] = z.
- Reset: synchronous and active-high. While i_rst is high, at every clock edge:
  - o_cdc_vld, o_cdc_data, o_inflight, o_err, the FIFO pointers and the FIFO count go to 0.
  - o_rsp_vld = 0, o_busy = 0, o_req_rdy = 0.
  - FIFO storage contents are don't-care.
  - A reset in mid-operation discards all in-flight and buffered results. Results arriving from the core afterwards count as spurious (see below).
- Credit rule:
  - used = inflight + fifo_count.
  - o_req_rdy = !i_rst && (used < FIFO_DEPTH). It is a combinational function of registers only; it does not depend on i_req_vld.
- Issue:
  - On an accepted request at edge N, o_cdc_data is registered with the packed word and o_cdc_vld = 1 during cycle N+1.
  - o_cdc_vld is a single-cycle pulse per request. Back-to-back accepts give consecutive pulses.
  - When no request is accepted, o_cdc_vld = 0 and o_cdc_data holds its last value.
  - inflight increments on the accept edge.
- Return:
  - Sampled when i_cdc_vld = 1 at edge M.
  - If inflight > 0: the word is written to the FIFO at the tail and inflight decrements.
  - If inflight == 0 (spurious): the word is dropped and o_err is set.
  - If the FIFO is full at a write (unreachable under the credit rule): the word is dropped and o_err is set.
  - o_err clears only on reset.
- FIFO:
  - Show-ahead: the head entry is visible on o_rsp_* while o_rsp_vld = 1.
  - A written result appears on o_rsp_* in cycle M+1 when the FIFO was empty. Write-to-read latency is 1 cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_rsp_* hold steady while o_rsp_vld is high and i_rsp_rdy is low.
  - Results are returned in issue order.
- Simultaneous events in one cycle:
  - Accept and return: inflight is unchanged.
  - Return and pop: fifo_count is unchanged.
  - Accept, return and pop: all three updates apply.
  - Pop with the FIFO full plus a new accept is legal: the credit freed by the pop is visible from the next cycle only.
- o_busy = (inflight != 0) || (fifo_count != 0), registered-derived.

Test Plan:
- Single op: after reset, request mode=0, x=0x4000, y=0, z=0x2000 → o_cdc_vld pulses one cycle later with o_cdc_data = 49'h0_4000_0000_2000 and o_inflight = 1. The bench model returns 49'h1_2D41_2D41_0000 → o_rsp_vld next cycle with x = y = 0x2D41, mode = 1 and o_inflight = 0.
- Credit exhaustion: FIFO_DEPTH = 8, i_rsp_rdy = 0, continuous requests with the core model at 12-cycle latency → exactly 8 accepted; o_req_rdy drops after the 8th; all 8 results are buffered; o_err = 0.
- Drain and refill: from the full state, hold i_rsp_rdy high → one pop per cycle in issue order; o_req_rdy returns to 1 the cycle after the first pop.
- Simultaneous accept, return and pop every cycle for 50 cycles → counters stay constant; o_err = 0; output sequence equals input sequence.
- Spurious result: i_cdc_vld = 1 while o_inflight = 0 → o_err = 1 and stays high; o_rsp_vld remains 0.
- Reset mid-operation: i_rst pulsed with 3 ops in flight and 2 results buffered → all outputs 0 the next cycle. The 3 late results each set o_err and are dropped.

Source files
------------

// File: rtl/cordic_host_if.sv
// Host-side adapter for the CORDIC core: packs requests, issues them against
// result-FIFO credits, and returns unpacked results through a show-ahead FIFO.
module cordic_host_if #(
  parameter int unsigned TOTAL_WIDTH = 49,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_vld,
  output logic                   o_req_rdy,
  input  logic                   i_req_mode,
  input  logic [DATA_WIDTH-1:0]  i_req_x,
  input  logic [DATA_WIDTH-1:0]  i_req_y,
  input  logic [DATA_WIDTH-1:0]  i_req_z,
  output logic                   o_cdc_vld,
  output logic [TOTAL_WIDTH-1:0] o_cdc_data,
  input  logic                   i_cdc_vld,
  input  logic [TOTAL_WIDTH-1:0] i_cdc_data,
  output logic                   o_rsp_vld,
  input  logic                   i_rsp_rdy,
  output logic                   o_rsp_mode,
  output logic [DATA_WIDTH-1:0]  o_rsp_x,
  output logic [DATA_WIDTH-1:0]  o_rsp_y,
  output logic [DATA_WIDTH-1:0]  o_rsp_z,
  output logic [CNT_W-1:0]       o_inflight,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned MODE_B = 3 * DATA_WIDTH;
  localparam logic [CNT_W:0]   DEPTH_U = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

  logic [TOTAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_inflight;
  logic                   r_cdc_vld;
  logic [TOTAL_WIDTH-1:0] r_cdc_data;
  logic                   r_err;

  logic [CNT_W:0]         w_used;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_ret_ok;
  logic                   w_spurious;
  logic                   w_full;
  logic                   w_wr;
  logic [TOTAL_WIDTH-1:0] w_req_word;
  logic [TOTAL_WIDTH-1:0] w_head;

  // Credits: every issued request already owns a FIFO slot for its result.
  assign w_used     = {1'b0, r_inflight} + {1'b0, r_cnt};
  assign o_req_rdy  = !i_rst && (w_used < DEPTH_U);
  assign w_accept   = i_req_vld && o_req_rdy;
  assign w_pop      = (r_cnt != '0) && i_rsp_rdy;
  assign w_ret_ok   = i_cdc_vld && (r_inflight != '0);
  assign w_spurious = i_cdc_vld && (r_inflight == '0);
  assign w_full     = (r_cnt == FULL_C);
  assign w_wr       = w_ret_ok && !w_full;
  assign w_req_word = TOTAL_WIDTH'({i_req_mode, i_req_x, i_req_y, i_req_z});
  assign w_head     = r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cdc_vld  <= 1'b0;
      r_cdc_data <= '0;
      r_inflight <= '0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_cdc_vld <= w_accept;
      if (w_accept) begin
        r_cdc_data <= w_req_word;
      end

      if (w_accept && !w_ret_ok) begin
        r_inflight <= r_inflight + CNT_W'(1);
      end else if (!w_accept && w_ret_ok) begin
        r_inflight <= r_inflight - CNT_W'(1);
      end

      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end

      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // Sticky until reset: a result nobody asked for, or one with no slot.
      if (w_spurious || (w_ret_ok && w_full)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_cdc_data;
    end
  end

  assign o_cdc_vld  = r_cdc_vld;
  assign o_cdc_data = r_cdc_data;
  assign o_inflight = r_inflight;
  assign o_err      = r_err;
  assign o_rsp_vld  = (r_cnt != '0);
  assign o_busy     = (r_inflight != '0) || (r_cnt != '0);
  assign o_rsp_mode = w_head[MODE_B];
  assign o_rsp_x    = w_head[MODE_B-1 -: DATA_WIDTH];
  assign o_rsp_y    = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign o_rsp_z    = w_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_cordic_host_if.sv
// Randomized scoreboard bench for cordic_host_if with a fixed-latency core model.
module tb_cordic_host_if;

  localparam int DW    = 16;
  localparam int TW    = 49;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_req_vld;
  logic          o_req_rdy;
  logic          i_req_mode;
  logic [DW-1:0] i_req_x, i_req_y, i_req_z;
  logic          o_cdc_vld;
  logic [TW-1:0] o_cdc_data;
  logic          i_cdc_vld;
  logic [TW-1:0] i_cdc_data;
  logic          o_rsp_vld;
  logic          i_rsp_rdy;
  logic          o_rsp_mode;
  logic [DW-1:0] o_rsp_x, o_rsp_y, o_rsp_z;
  logic [CW-1:0] o_inflight;
  logic          o_busy;
  logic          o_err;

  always #5 i_clk = ~i_clk;

  cordic_host_if #(
    .TOTAL_WIDTH(TW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy), .i_req_mode(i_req_mode),
    .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_z(i_req_z),
    .o_cdc_vld(o_cdc_vld), .o_cdc_data(o_cdc_data),
    .i_cdc_vld(i_cdc_vld), .i_cdc_data(i_cdc_data),
    .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy), .o_rsp_mode(o_rsp_mode),
    .o_rsp_x(o_rsp_x), .o_rsp_y(o_rsp_y), .o_rsp_z(o_rsp_z),
    .o_inflight(o_inflight), .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    int            due;
    logic [TW-1:0] w;
  } pend_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            lat = 4;
  int            m_infl = 0;
  int            n_acc = 0;
  bit            inject_spur = 1'b0;
  int            s_infl;
  bit            s_rdy;
  bit            s_rsp_vld;
  pend_t         pend_q[$];
  logic [TW-1:0] exp_issue_q[$];
  logic [TW-1:0] exp_rsp_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [TW-1:0] pack(input logic m, input logic [DW-1:0] x,
                                         input logic [DW-1:0] y, input logic [DW-1:0] z);
    return {m, x, y, z};
  endfunction

  // Stand-in for the CORDIC arithmetic: one known vector, otherwise a reversible scramble.
  function automatic logic [TW-1:0] core_fn(input logic [TW-1:0] w);
    if (w == 49'h0_4000_0000_2000) return 49'h1_2D41_2D41_0000;
    return {~w[TW-1], w[TW-2:0] ^ 48'hA5A5_3C3C_0FF0};
  endfunction

  // Core model: checks each issued word, returns its result lat cycles later.
  initial begin : core_model
    pend_t p;
    i_cdc_vld  = 1'b0;
    i_cdc_data = '0;
    forever begin
      @(negedge i_clk);
      if (o_cdc_vld === 1'b1) begin
        if (exp_issue_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got %0h required none", o_cdc_data);
        end else begin
          chk("issue_word", 64'(o_cdc_data), 64'(exp_issue_q.pop_front()));
        end
        pend_q.push_back('{cyc + lat, core_fn(o_cdc_data)});
        m_infl++;
      end
      chk("inflight", 64'(o_inflight), 64'(m_infl));
      if (inject_spur) begin
        i_cdc_vld   = 1'b1;
        i_cdc_data  = TW'({$urandom, $urandom});
        inject_spur = 1'b0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        p          = pend_q.pop_front();
        i_cdc_vld  = 1'b1;
        i_cdc_data = p.w;
        if (m_infl > 0) m_infl--;
      end else begin
        i_cdc_vld = 1'b0;
      end
    end
  end

  // Response monitor: every pop must match the oldest outstanding expectation.
  initial begin : rsp_monitor
    forever begin
      @(negedge i_clk);
      if (o_rsp_vld === 1'b1 && i_rsp_rdy === 1'b1) begin
        if (exp_rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got %0h required none",
                   {o_rsp_mode, o_rsp_x, o_rsp_y, o_rsp_z});
        end else begin
          chk("rsp_word", 64'({o_rsp_mode, o_rsp_x, o_rsp_y, o_rsp_z}),
              64'(exp_rsp_q.pop_front()));
        end
      end
    end
  end

  // One clock of stimulus; starts and ends just after a rising edge.
  task automatic drive_req(input bit vld, input logic m, input logic [DW-1:0] x,
                           input logic [DW-1:0] y, input logic [DW-1:0] z, input bit rdy);
    logic [TW-1:0] w;
    i_req_vld  = vld;
    i_req_mode = m;
    i_req_x    = x;
    i_req_y    = y;
    i_req_z    = z;
    i_rsp_rdy  = rdy;
    @(negedge i_clk);
    s_rdy     = o_req_rdy;
    s_infl    = int'(o_inflight);
    s_rsp_vld = o_rsp_vld;
    if (vld && o_req_rdy === 1'b1) begin
      w = pack(m, x, y, z);
      exp_issue_q.push_back(w);
      exp_rsp_q.push_back(core_fn(w));
      n_acc++;
    end
    @(posedge i_clk);
    #1;
    i_req_vld = 1'b0;
  endtask

  task automatic run(input int n, input int vpct, input int rpct);
    for (int i = 0; i < n; i++) begin
      drive_req($urandom_range(99) < vpct, 1'($urandom), DW'($urandom), DW'($urandom),
                DW'($urandom), $urandom_range(99) < rpct);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_rsp_q.size() == 0 && pend_q.size() == 0 && m_infl == 0) break;
      drive_req(1'b0, 1'b0, '0, '0, '0, 1'b1);
    end
    chk("drain_done", 64'(exp_rsp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cdc_vld"},  64'(o_cdc_vld), 64'd0);
    chk({tag, "_inflight"}, 64'(o_inflight), 64'd0);
    chk({tag, "_err"},      64'(o_err), 64'd0);
    chk({tag, "_rsp_vld"},  64'(o_rsp_vld), 64'd0);
    chk({tag, "_busy"},     64'(o_busy), 64'd0);
    chk({tag, "_req_rdy"},  64'(o_req_rdy), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int acc_cyc;
    bit seen;
    i_rst = 1'b1; i_req_vld = 1'b0; i_req_mode = 1'b0;
    i_req_x = '0; i_req_y = '0; i_req_z = '0; i_rsp_rdy = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_all_zero("reset");
    chk("reset_cdc_data", 64'(o_cdc_data), 64'd0);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Single known operation
    lat = 4;
    drive_req(1'b1, 1'b0, 16'h4000, 16'h0000, 16'h2000, 1'b0);
    chk("single_accept", 64'(s_rdy), 64'd1);
    @(negedge i_clk);
    acc_cyc = cyc;
    chk("single_cdc_vld", 64'(o_cdc_vld), 64'd1);
    chk("single_cdc_data", 64'(o_cdc_data), 64'h0_4000_0000_2000);
    chk("single_inflight", 64'(o_inflight), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (o_rsp_vld === 1'b1) seen = 1'b1;
    end
    chk("single_rsp_seen", 64'(seen), 64'd1);
    chk("single_latency", 64'(cyc - acc_cyc), 64'(lat + 1));
    chk("single_rsp_mode", 64'(o_rsp_mode), 64'd1);
    chk("single_rsp_x", 64'(o_rsp_x), 64'h2D41);
    chk("single_rsp_y", 64'(o_rsp_y), 64'h2D41);
    chk("single_rsp_z", 64'(o_rsp_z), 64'h0000);
    chk("single_busy", 64'(o_busy), 64'd1);
    @(posedge i_clk); #1;
    drain();

    // Credit exhaustion: nothing popped, long core latency
    lat = 12; n_acc = 0;
    run(30, 100, 0);
    chk("credit_accepts", 64'(n_acc), 64'(DEPTH));
    drive_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
    chk("credit_rdy_low", 64'(s_rdy), 64'd0);
    chk("credit_inflight", 64'(s_infl), 64'd0);
    chk("credit_buffered", 64'(s_rsp_vld), 64'd1);
    chk("credit_busy", 64'(o_busy), 64'd1);
    chk("credit_err", 64'(o_err), 64'd0);

    // Drain from full: credit returns the cycle after the first pop
    drive_req(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("drain_rdy_before", 64'(s_rdy), 64'd0);
    drive_req(1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("drain_rdy_after", 64'(s_rdy), 64'd1);
    drain();

    // Accept, return and pop every cycle: occupancy must not drift
    lat = 3;
    run(15, 100, 100);
    for (int i = 0; i < 50; i++) begin
      drive_req(1'b1, 1'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), 1'b1);
      chk("steady_inflight", 64'(s_infl), 64'(lat + 1));
      chk("steady_rsp_vld", 64'(s_rsp_vld), 64'd1);
      chk("steady_rdy", 64'(s_rdy), 64'd1);
    end
    drain();
    chk("steady_err", 64'(o_err), 64'd0);

    // Random traffic with random backpressure
    lat = 5;
    run(400, 60, 50);
    drain();
    chk("random_err", 64'(o_err), 64'd0);
    chk("random_busy", 64'(o_busy), 64'd0);

    // Spurious result while idle
    inject_spur = 1'b1;
    run(3, 0, 0);
    chk("spur_err", 64'(o_err), 64'd1);
    chk("spur_rsp_vld", 64'(o_rsp_vld), 64'd0);
    chk("spur_inflight", 64'(o_inflight), 64'd0);
    run(3, 0, 0);
    chk("spur_err_sticky", 64'(o_err), 64'd1);

    // Reset with 3 in flight and 2 buffered
    lat = 6;
    run(2, 100, 0);
    run(3, 0, 0);
    run(3, 100, 0);
    run(2, 0, 0);
    @(negedge i_clk);
    chk("midrst_pre_inflight", 64'(o_inflight), 64'd3);
    chk("midrst_pre_rsp_vld", 64'(o_rsp_vld), 64'd1);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    m_infl = 0;
    exp_rsp_q.delete();
    exp_issue_q.delete();
    @(negedge i_clk);
    chk_all_zero("midrst");
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;
    run(10, 0, 1);
    chk("late_err", 64'(o_err), 64'd1);
    chk("late_rsp_vld", 64'(o_rsp_vld), 64'd0);
    chk("late_inflight", 64'(o_inflight), 64'd0);
    chk("late_busy", 64'(o_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
